rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Parametrised round-robin arbiter: successor to the combinational lowest-bit priority bitscan.
- Adds a rotating priority pointer, registered one-hot grant, optional grant hold (lock) mode and an encoded grant index.
- Sits in front of shared resources (bus masters, FIFO write ports) inside the arbitration library.

Parameters:
- WIDTH, 8, number of requesters; legal range 2..64.
- HOLD, 1, 1 = granted requester keeps grant while its req stays high; 0 = re-arbitrate every cycle.
- IDW, $clog2(WIDTH), width of grant_id. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  WIDTH  request vector; bit i = requester i.
- grant  output  WIDTH  registered one-hot grant; all-zero when no grant.
- grant_valid  output  1  registered; high iff grant != 0.
- grant_id  output  IDW  registered binary index of the granted bit; 0 when grant_valid low.

Behaviour:
- Reset (rst high at clock edge): grant = 0, grant_valid = 0, grant_id = 0, priority pointer ptr = 0. rst has priority over all other activity, including mid-hold.
- ptr (IDW bits) is the highest-priority index. Search order is ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1 (wrap-around).
- Winner = first set bit of req in search order. Implementation: mask req with bits >= ptr and bitscan the masked vector. If the masked vector is zero, bitscan the unmasked req.
- Latency: one cycle. req sampled at edge N appears as grant after edge N.
- Arbitration cycle, taken when not holding:
  - If req == 0: grant -> 0, grant_valid -> 0, grant_id -> 0, ptr unchanged.
  - Else: grant -> onehot(winner), grant_id -> winner, grant_valid -> 1, ptr -> winner+1.
  - ptr wraps: winner = WIDTH-1 gives ptr -> 0. For non-power-of-2 WIDTH, ptr never exceeds WIDTH-1.
- Hold (HOLD=1):
  - Condition: grant_valid high and req[grant_id] high at the edge. Grant, grant_id and ptr are unchanged, regardless of other requests.
  - When req[grant_id] is low at the edge, a normal arbitration cycle occurs on that same edge. There is no idle bubble when other requests are pending.
- HOLD=0: every edge is an arbitration cycle. A continuously requesting holder loses priority after one grant cycle.
- Fairness: with all WIDTH requests continuously high and HOLD=0, each requester is granted exactly once per WIDTH consecutive cycles.
- A requester dropping req while granted does not cause a combinational glitch on outputs; outputs change only at edges.
- grant is always one-hot or zero. grant_id is always consistent with grant.
- Simultaneous requests: only the first in search order wins. The losers keep waiting with no internal queueing; req is level-based.

Test Plan:
- Reset: drive req=8'hFF with rst high for 2 cycles -> grant=0, grant_valid=0, grant_id=0. Release rst, hold req=8'h00 -> outputs stay 0.
- Rotation (HOLD=0, WIDTH=8): req=8'hFF for 9 cycles -> grant sequence 01,02,04,08,10,20,40,80,01; grant_id 0..7,0.
- Sparse/wrap (HOLD=0): req=8'b1000_0101 constant -> grant 01,04,80,01,...
  - Then ptr=1 (after grant 01), req=8'b0000_0001 -> grant 01 (wrap search).
- Hold (HOLD=1): req=8'h06 -> grant 02, held 5 cycles while req[1] high.
  - Drop req[1] (req=8'h04) -> grant 04 on the next edge, no zero cycle.
  - Then req=0 -> grant 00, grant_valid 0.
- Reset mid-hold (HOLD=1): grant=08 held with req=8'h08. Assert rst one cycle -> grant 00.
  - Release rst with req=8'h09 -> grant 01, because ptr was reset to 0.
- Non-power-of-2 (WIDTH=5, HOLD=0): req=5'b11111 for 6 cycles -> grant_id 0,1,2,3,4,0. ptr never reaches 5–7.

Source files
------------

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a rotating priority pointer, registered one-hot grant,
// encoded grant index and optional grant hold while the holder keeps requesting.
module rr_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter bit          HOLD  = 1'b1,
  parameter int unsigned IDW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [IDW-1:0]   grant_id
);

  logic [IDW-1:0]   ptr;
  logic [WIDTH-1:0] masked;
  logic [IDW-1:0]   winner;
  logic             found;
  logic             any_req;
  logic             hold_now;
  logic [IDW-1:0]   ptr_next;

  always_comb begin
    masked = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      masked[i] = req[i] && (i >= 32'(ptr));
    end
  end

  // Lowest set bit at or above ptr; if none, fall back to lowest set bit overall.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && masked[i]) begin
        winner = IDW'(i);
        found  = 1'b1;
      end
    end
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (!found && req[i]) begin
        winner = IDW'(i);
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    any_req  = |req;
    hold_now = HOLD && grant_valid && req[grant_id];
    ptr_next = (winner == IDW'(WIDTH - 1)) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      ptr         <= '0;
    end else if (!hold_now) begin
      if (any_req) begin
        grant       <= WIDTH'(1) << winner;
        grant_valid <= 1'b1;
        grant_id    <= winner;
        ptr         <= ptr_next;
      end else begin
        grant       <= '0;
        grant_valid <= 1'b0;
        grant_id    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed vector tables on three configurations
// (8/no-hold, 8/hold, 5/no-hold) followed by random stimulus against a reference model.
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_a, req_h;
  logic [4:0] req_f;
  logic [7:0] grant_a, grant_h;
  logic [4:0] grant_f;
  logic       valid_a, valid_h, valid_f;
  logic [2:0] id_a, id_h, id_f;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.WIDTH(8), .HOLD(1'b0)) u_a (
    .clk(clk), .rst(rst), .req(req_a),
    .grant(grant_a), .grant_valid(valid_a), .grant_id(id_a)
  );

  rr_arbiter #(.WIDTH(8), .HOLD(1'b1)) u_h (
    .clk(clk), .rst(rst), .req(req_h),
    .grant(grant_h), .grant_valid(valid_h), .grant_id(id_h)
  );

  rr_arbiter #(.WIDTH(5), .HOLD(1'b0)) u_f (
    .clk(clk), .rst(rst), .req(req_f),
    .grant(grant_f), .grant_valid(valid_f), .grant_id(id_f)
  );

  typedef struct {
    bit         rst;
    logic [7:0] req;
    logic [7:0] grant;
    bit         valid;
    logic [2:0] id;
  } vec_t;

  typedef struct {
    int ptr;
    int id;
    bit valid;
  } mstate_t;

  vec_t tab_a[$];
  vec_t tab_h[$];
  vec_t tab_f[$];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // which: 0 = 8-bit no-hold, 1 = 8-bit hold, 2 = 5-bit no-hold
  task automatic run_vec(input int which, input vec_t v, input string tag);
    rst   = v.rst;
    req_a = (which == 0) ? v.req : 8'h00;
    req_h = (which == 1) ? v.req : 8'h00;
    req_f = (which == 2) ? v.req[4:0] : 5'h00;
    @(posedge clk);
    #1;
    case (which)
      0: begin
        check({tag, ".grant"}, grant_a, v.grant);
        check({tag, ".valid"}, {7'b0, valid_a}, {7'b0, v.valid});
        check({tag, ".id"}, {5'b0, id_a}, {5'b0, v.id});
      end
      1: begin
        check({tag, ".grant"}, grant_h, v.grant);
        check({tag, ".valid"}, {7'b0, valid_h}, {7'b0, v.valid});
        check({tag, ".id"}, {5'b0, id_h}, {5'b0, v.id});
      end
      default: begin
        check({tag, ".grant"}, {3'b0, grant_f}, v.grant);
        check({tag, ".valid"}, {7'b0, valid_f}, {7'b0, v.valid});
        check({tag, ".id"}, {5'b0, id_f}, {5'b0, v.id});
      end
    endcase
  endtask

  // Reference: scan the requesters in wrap-around order starting at ptr.
  function automatic mstate_t mstep(mstate_t s, int w, bit hold, bit r_st, logic [7:0] r);
    mstate_t n = s;
    int win = -1;
    if (r_st) begin
      n.ptr = 0; n.id = 0; n.valid = 1'b0;
      return n;
    end
    if (hold && s.valid && r[s.id]) return n;
    for (int k = 0; k < w; k++) begin
      if (win < 0 && r[(s.ptr + k) % w]) win = (s.ptr + k) % w;
    end
    if (win < 0) begin
      n.valid = 1'b0; n.id = 0;
    end else begin
      n.valid = 1'b1; n.id = win; n.ptr = (win + 1) % w;
    end
    return n;
  endfunction

  function automatic logic [7:0] mgrant(mstate_t s);
    return s.valid ? (8'h01 << s.id) : 8'h00;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mstate_t ma, mh, mf;
    logic [7:0] ra, rh;
    logic [4:0] rf;
    bit rs;

    rst = 1'b1; req_a = '0; req_h = '0; req_f = '0;

    // No-hold, WIDTH=8: reset, idle, full rotation, sparse wrap-around
    tab_a.push_back('{1'b1, 8'hFF, 8'h00, 1'b0, 3'd0});
    tab_a.push_back('{1'b1, 8'hFF, 8'h00, 1'b0, 3'd0});
    tab_a.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 3'd0});
    tab_a.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 3'd0});
    for (int i = 0; i < 9; i++)
      tab_a.push_back('{1'b0, 8'hFF, 8'h01 << (i % 8), 1'b1, 3'(i % 8)});
    tab_a.push_back('{1'b1, 8'h85, 8'h00, 1'b0, 3'd0});
    tab_a.push_back('{1'b0, 8'h85, 8'h01, 1'b1, 3'd0});
    tab_a.push_back('{1'b0, 8'h85, 8'h04, 1'b1, 3'd2});
    tab_a.push_back('{1'b0, 8'h85, 8'h80, 1'b1, 3'd7});
    tab_a.push_back('{1'b0, 8'h85, 8'h01, 1'b1, 3'd0});
    tab_a.push_back('{1'b0, 8'h01, 8'h01, 1'b1, 3'd0});
    tab_a.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 3'd0});
    tab_a.push_back('{1'b0, 8'h80, 8'h80, 1'b1, 3'd7});
    tab_a.push_back('{1'b0, 8'h80, 8'h80, 1'b1, 3'd7});

    // Hold, WIDTH=8: hold, hand-off without bubble, release, reset mid-hold
    tab_h.push_back('{1'b1, 8'h00, 8'h00, 1'b0, 3'd0});
    for (int i = 0; i < 6; i++)
      tab_h.push_back('{1'b0, 8'h06, 8'h02, 1'b1, 3'd1});
    tab_h.push_back('{1'b0, 8'h04, 8'h04, 1'b1, 3'd2});
    tab_h.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 3'd0});
    tab_h.push_back('{1'b0, 8'h08, 8'h08, 1'b1, 3'd3});
    tab_h.push_back('{1'b0, 8'h08, 8'h08, 1'b1, 3'd3});
    tab_h.push_back('{1'b0, 8'h0C, 8'h08, 1'b1, 3'd3});
    tab_h.push_back('{1'b1, 8'h08, 8'h00, 1'b0, 3'd0});
    tab_h.push_back('{1'b0, 8'h09, 8'h01, 1'b1, 3'd0});
    tab_h.push_back('{1'b0, 8'h09, 8'h01, 1'b1, 3'd0});
    tab_h.push_back('{1'b0, 8'h08, 8'h08, 1'b1, 3'd3});

    // WIDTH=5: pointer must wrap from 4 back to 0
    tab_f.push_back('{1'b1, 8'h1F, 8'h00, 1'b0, 3'd0});
    for (int i = 0; i < 6; i++)
      tab_f.push_back('{1'b0, 8'h1F, 8'h01 << (i % 5), 1'b1, 3'(i % 5)});
    tab_f.push_back('{1'b0, 8'h11, 8'h10, 1'b1, 3'd4});
    tab_f.push_back('{1'b0, 8'h11, 8'h01, 1'b1, 3'd0});

    foreach (tab_a[i]) run_vec(0, tab_a[i], $sformatf("nohold8[%0d]", i));
    foreach (tab_h[i]) run_vec(1, tab_h[i], $sformatf("hold8[%0d]", i));
    foreach (tab_f[i]) run_vec(2, tab_f[i], $sformatf("w5[%0d]", i));

    // Random phase: all three DUTs against the reference model
    rst = 1'b1; req_a = '0; req_h = '0; req_f = '0;
    @(posedge clk); #1;
    ma = '{0, 0, 1'b0}; mh = '{0, 0, 1'b0}; mf = '{0, 0, 1'b0};
    ra = '0; rh = '0; rf = '0;
    for (int c = 0; c < 400; c++) begin
      rs = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 0) ra = 8'($urandom) & ($urandom_range(0, 1) ? 8'hFF : 8'($urandom));
      if ($urandom_range(0, 2) == 0) rh = 8'($urandom) & ($urandom_range(0, 1) ? 8'hFF : 8'($urandom));
      if ($urandom_range(0, 1) == 0) rf = 5'($urandom) & ($urandom_range(0, 1) ? 5'h1F : 5'($urandom));
      rst = rs; req_a = ra; req_h = rh; req_f = rf;
      ma = mstep(ma, 8, 1'b0, rs, ra);
      mh = mstep(mh, 8, 1'b1, rs, rh);
      mf = mstep(mf, 5, 1'b0, rs, {3'b0, rf});
      @(posedge clk);
      #1;
      check("rnd_a.grant", grant_a, mgrant(ma));
      check("rnd_a.valid", {7'b0, valid_a}, {7'b0, ma.valid});
      check("rnd_a.id", {5'b0, id_a}, 8'(ma.id));
      check("rnd_h.grant", grant_h, mgrant(mh));
      check("rnd_h.valid", {7'b0, valid_h}, {7'b0, mh.valid});
      check("rnd_h.id", {5'b0, id_h}, 8'(mh.id));
      check("rnd_f.grant", {3'b0, grant_f}, mgrant(mf));
      check("rnd_f.valid", {7'b0, valid_f}, {7'b0, mf.valid});
      check("rnd_f.id", {5'b0, id_f}, 8'(mf.id));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
